// File: rtl/bitwise_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NAND) among NREQ requesters.
// Latency: accept at edge N, result valid after edge N; one accept per cycle while resp_ready is high.
// Backpressure: no grant while a result is held with resp_ready low; resp_ready feeds req_ready combinationally.
module bitwise_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  output logic [WIDTH-1:0]      resp_data,
  output logic [1:0]            resp_id,
  input  logic                  resp_ready
);

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  logic [1:0]       r_ptr;
  logic             r_resp_valid;
  logic [WIDTH-1:0] r_resp_data;
  logic [1:0]       r_resp_id;

  logic             w_free;
  logic             w_found;
  logic [1:0]       w_idx;
  logic [1:0]       w_gnt_idx;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;

  // Slot is free when empty or being drained this cycle; grants are suppressed during reset.
  assign w_free = (!r_resp_valid || resp_ready) && reset_n;

  // Round-robin search starting at r_ptr, wrapping modulo NREQ; idle requesters are skipped.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = 2'd0;
    w_idx     = 2'd0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = 2'((int'(r_ptr) + k) % NREQ);
      if (!w_found && w_free && req_valid[w_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
    if (w_found) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  // Shared bitwise unit, fed from the granted requester's slices.
  always_comb begin
    w_op     = req_op[2*w_gnt_idx +: 2];
    w_a      = req_a[WIDTH*w_gnt_idx +: WIDTH];
    w_b      = req_b[WIDTH*w_gnt_idx +: WIDTH];
    w_result = '0;
    case (op_e'(w_op))
      OP_AND:  w_result = w_a & w_b;
      OP_OR:   w_result = w_a | w_b;
      OP_XOR:  w_result = w_a ^ w_b;
      OP_NAND: w_result = ~(w_a & w_b);
      default: w_result = '0;
    endcase
  end

  // Result register and pointer: an accept overwrites (even while draining), a bare drain clears valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr        <= 2'd0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= 2'd0;
    end else if (w_found) begin
      r_ptr        <= 2'((int'(w_gnt_idx) + 1) % NREQ);
      r_resp_valid <= 1'b1;
      r_resp_data  <= w_result;
      r_resp_id    <= w_gnt_idx;
    end else if (r_resp_valid && resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
`timescale 1ns/1ps
module tb_bitwise_unit_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic [WIDTH-1:0]      resp_data;
  logic [1:0]            resp_id;
  logic                  resp_ready;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int               m_ptr;
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_id;

  bitwise_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Winner index by the round-robin rule, or -1 when nothing may be granted.
  function automatic int model_grant();
    if (m_valid && !resp_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] grant_vec(input int g);
    logic [NREQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid[i]           = v;
    req_op[2*i +: 2]       = op;
    req_a[WIDTH*i +: WIDTH] = a;
    req_b[WIDTH*i +: WIDTH] = b;
  endtask

  task automatic model_clear();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 0;
  endtask

  // Advance one clock; model follows the same edge. Returns at the next falling edge.
  task automatic tick(output int g);
    g = model_grant();
    @(posedge clk);
    if (g >= 0) begin
      m_data  = ref_op(req_op[2*g +: 2], req_a[WIDTH*g +: WIDTH], req_b[WIDTH*g +: WIDTH]);
      m_id    = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % NREQ;
    end else if (m_valid && resp_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    reset_n   = 1'b0;
    #2;
    reset_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int g;
    reset_n    = 1'b0;
    req_valid  = '1;
    req_op     = '0;
    req_a      = '1;
    req_b      = '1;
    resp_ready = 1'b1;
    model_clear();
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", resp_valid); end
    total++; if (resp_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0000", resp_data); end
    total++; if (resp_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", resp_id); end
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0 || req_ready !== '0) begin bad++; $display("FAIL reset_hold got valid=%b ready=%b want 0/0000", resp_valid, req_ready); end
    @(negedge clk);
    req_valid = '0;
    reset_n   = 1'b1;
    @(negedge clk);
    g = 0;
  endtask

  task automatic test_single();
    int g;
    do_reset();
    resp_ready = 1'b1;
    set_req(2, 1'b1, 2'b00, 16'hF0F0, 16'hFF00);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b want=0100", req_ready); end
    tick(g);
    total++; if (resp_valid !== 1'b1 || resp_data !== 16'hF000 || resp_id !== 2'd2) begin
      bad++; $display("FAIL single_result got v=%b d=%h id=%0d want v=1 d=f000 id=2", resp_valid, resp_data, resp_id);
    end
    // Requester 2 drops; with everyone valid the next winner shows ptr is 3
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'b01, 16'h1234, 16'h0F0F);
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL single_ptr got=%b want=1000", req_ready); end
    tick(g);
    req_valid = '0;
    tick(g);
  endtask

  task automatic test_opcodes();
    int g;
    logic [WIDTH-1:0] want [3];
    want[0] = 16'h0FFF; want[1] = 16'h0FF0; want[2] = 16'hFFF0;
    do_reset();
    resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b1, 2'(k + 1), 16'h00FF, 16'h0F0F);
      tick(g);
      total++; if (resp_data !== want[k] || resp_id !== 2'd0 || resp_valid !== 1'b1) begin
        bad++; $display("FAIL opcode_%0d got d=%h id=%0d v=%b want d=%h id=0 v=1", k + 1, resp_data, resp_id, resp_valid, want[k]);
      end
    end
    req_valid = '0;
    tick(g);
  endtask

  task automatic test_fairness();
    int g;
    do_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
    for (int c = 0; c < 8; c++) begin
      #1;
      total++; if (req_ready !== grant_vec(c % NREQ)) begin bad++; $display("FAIL fair_grant c=%0d got=%b want=%b", c, req_ready, grant_vec(c % NREQ)); end
      tick(g);
      total++; if (resp_valid !== 1'b1 || resp_id !== 2'(c % NREQ) || resp_data !== m_data) begin
        bad++; $display("FAIL fair_result c=%0d got v=%b id=%0d d=%h want v=1 id=%0d d=%h", c, resp_valid, resp_id, resp_data, c % NREQ, m_data);
      end
      // Winner re-presents a fresh request immediately
      set_req(c % NREQ, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
    end
    req_valid = '0;
    tick(g);
  endtask

  task automatic test_backpressure();
    int g;
    logic [WIDTH-1:0] h_data;
    logic [1:0]       h_id;
    do_reset();
    resp_ready = 1'b0;
    set_req(1, 1'b1, 2'b10, 16'hAAAA, 16'h0FF0);
    set_req(3, 1'b1, 2'b11, 16'hC3C3, 16'hFF00);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_first_grant got=%b want=0010", req_ready); end
    tick(g);
    h_data = resp_data;
    h_id   = resp_id;
    total++; if (h_data !== 16'hA55A || h_id !== 2'd1) begin bad++; $display("FAIL bp_first_result got d=%h id=%0d want d=a55a id=1", h_data, h_id); end
    set_req(1, 1'b1, 2'b01, 16'h0001, 16'h0002);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready !== '0) begin bad++; $display("FAIL bp_stall_ready c=%0d got=%b want=0000", c, req_ready); end
      tick(g);
      total++; if (resp_valid !== 1'b1 || resp_data !== h_data || resp_id !== h_id) begin
        bad++; $display("FAIL bp_stall_hold c=%0d got v=%b d=%h id=%0d want v=1 d=%h id=%0d", c, resp_valid, resp_data, resp_id, h_data, h_id);
      end
    end
    resp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_release_grant got=%b want=1000", req_ready); end
    tick(g);
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_data !== 16'h3CFF) begin
      bad++; $display("FAIL bp_release_result got v=%b id=%0d d=%h want v=1 id=3 d=3cff", resp_valid, resp_id, resp_data);
    end
    req_valid = '0;
    tick(g);
  endtask

  task automatic test_skip_idle();
    int g;
    do_reset();
    resp_ready = 1'b1;
    set_req(0, 1'b1, 2'b00, 16'hFFFF, 16'h1111);
    tick(g);
    set_req(0, 1'b1, 2'b01, 16'h0100, 16'h0010);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL skip_grant got=%b want=0001", req_ready); end
    tick(g);
    total++; if (resp_id !== 2'd0 || resp_data !== 16'h0110) begin bad++; $display("FAIL skip_result got id=%0d d=%h want id=0 d=0110", resp_id, resp_data); end
    set_req(1, 1'b1, 2'b00, 16'h0000, 16'h0000);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL skip_ptr got=%b want=0010", req_ready); end
    req_valid = '0;
    tick(g);
  endtask

  task automatic test_reset_mid();
    int g;
    do_reset();
    resp_ready = 1'b0;
    set_req(1, 1'b1, 2'b01, 16'h1234, 16'h4321);
    tick(g);
    set_req(1, 1'b0, 2'b00, 16'h0, 16'h0);
    set_req(2, 1'b1, 2'b10, 16'hFFFF, 16'h00FF);
    set_req(3, 1'b1, 2'b01, 16'h0F00, 16'h00F0);
    #1;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre got v=%b want 1", resp_valid); end
    reset_n = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0 || resp_data !== '0 || resp_id !== 2'd0 || req_ready !== '0) begin
      bad++; $display("FAIL rmid_async got v=%b d=%h id=%0d rdy=%b want 0/0000/0/0000", resp_valid, resp_data, resp_id, req_ready);
    end
    #1;
    reset_n = 1'b1;
    model_clear();
    resp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rmid_grant got=%b want=0100", req_ready); end
    tick(g);
    total++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 16'hFF00) begin
      bad++; $display("FAIL rmid_result got v=%b id=%0d d=%h want v=1 id=2 d=ff00", resp_valid, resp_id, resp_data);
    end
    req_valid = '0;
    tick(g);
  endtask

  task automatic test_random();
    int g;
    g = -1;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || i == g)
          set_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      total++; if (req_ready !== grant_vec(model_grant())) begin
        bad++; $display("FAIL rand_grant c=%0d got=%b want=%b", c, req_ready, grant_vec(model_grant()));
      end
      tick(g);
      total++; if (resp_valid !== m_valid || resp_data !== m_data || resp_id !== 2'(m_id)) begin
        bad++; $display("FAIL rand_result c=%0d got v=%b d=%h id=%0d want v=%b d=%h id=%0d", c, resp_valid, resp_data, resp_id, m_valid, m_data, m_id);
      end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_opcodes();
    test_fairness();
    test_backpressure();
    test_skip_idle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
